debounce_multi: RTL and testbench
=================================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, the number of independent input channels (1..32).
REQ-002 SHALL have parameter STABLE_CYCLES, default 16, the number of consecutive differing samples required to accept a new level (2..65535).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; when 1, raw low means asserted (pressed).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous to clk and active-high.
REQ-006 SHALL have port sample_en, input, 1 bit, the sample-qualify tick; tie to 1 to sample every cycle.
REQ-007 SHALL have port raw_in, input, CHANNELS bits, asynchronous bouncing inputs.
REQ-008 SHALL have port db_out, output, CHANNELS bits, the debounced asserted level (1 = asserted), registered.
REQ-009 SHALL have port rise_pulse, output, CHANNELS bits, a one-cycle strobe when db_out goes 0->1, registered.
REQ-010 SHALL have port fall_pulse, output, CHANNELS bits, a one-cycle strobe when db_out goes 1->0, registered.

Function
REQ-011 SHALL pass each raw_in bit through a 2-flop synchronizer, then apply polarity (invert when ACTIVE_LOW=1) to form sync_lvl.
REQ-012 SHALL keep a per-channel counter of width clog2(STABLE_CYCLES+1), saturating and never wrapping.
REQ-013 SHALL leave the counter unchanged on a cycle where sample_en=0; the synchronizer still advances every cycle.
REQ-014 SHALL, when sample_en=1 and sync_lvl equals db_out, clear the counter to 0 (glitch rejection).
REQ-015 SHALL, when sample_en=1 and sync_lvl differs from db_out, increment the counter.
REQ-016 SHALL, when that increment reaches STABLE_CYCLES, toggle db_out on the same edge and clear the counter.
REQ-017 SHALL give a latency with sample_en=1 constant of exactly 2+STABLE_CYCLES clk edges from the first edge sampling the new raw level to db_out changing.
REQ-018 SHALL assert rise_pulse/fall_pulse on the same edge db_out toggles, for exactly one cycle; the two are never both high on one channel.
REQ-019 SHALL process channels independently; simultaneous toggles on several channels all produce their pulses in the same cycle.
REQ-020 SHALL treat an input that bounces on the last sample before threshold as a full restart: the counter goes to 0 and the full STABLE_CYCLES are required again.

Reset
REQ-021 SHALL, while rst=1, clear db_out, rise_pulse, fall_pulse and all counters to 0 on the next edge.
REQ-022 SHALL, while rst=1, preload synchronizer flops with the deasserted raw level (1 if ACTIVE_LOW=1, else 0).
REQ-023 SHALL give rst priority over sample_en and any in-progress count; reset mid-count discards the count with no pulse.
REQ-024 SHALL, after rst deasserts with raw held asserted, see db_out rise after 2+STABLE_CYCLES edges, with a rise_pulse.

Structure
REQ-025 SHALL place in shared package debounce_pkg the default constants (DB_STABLE_DEFAULT=16, DB_SYNC_STAGES=2) and the clog2-based counter-width function.
REQ-026 SHALL implement one channel (synchronizer, counter, state, pulse flops) as sub-module debounce_chan, instantiated CHANNELS times by generate.
REQ-027 SHALL register all outputs, with no combinational path from raw_in to any output.

Verification (CHANNELS=4, STABLE_CYCLES=4, ACTIVE_LOW=1 unless stated)
REQ-028 SHALL verify clean press: raw_in[0] 1->0 held -> db_out[0]=1 and rise_pulse[0]=1 for one cycle exactly 6 edges later; other channels stay 0.
REQ-029 SHALL verify bounce: raw_in[1] low 3 cycles, high 1, low held -> db_out[1] rises only 6 edges after the final falling sample, with a single rise_pulse.
REQ-030 SHALL verify release and simultaneity: channels 0 and 2 asserted, both raw released on the same edge -> fall_pulse=4'b0101 on one cycle, db_out cleared.
REQ-031 SHALL verify prescale: sample_en high 1 cycle in 4, raw_in[3] pressed -> db_out[3] rises after 4 qualified samples (~16+2 edges), never earlier.
REQ-032 SHALL verify reset mid-count: rst pulsed 1 cycle after 3 of 4 samples -> no pulse, and the full 6-edge latency restarts after rst falls.
REQ-033 SHALL verify polarity: ACTIVE_LOW=0 and raw_in[0] 0->1 held -> db_out[0] rises 6 edges later.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, state type and sizing helper for the multi-channel debouncer.
package debounce_pkg;

    localparam int DB_STABLE_DEFAULT = 16;
    localparam int DB_SYNC_STAGES    = 2;

    // Debounced level held by each channel.
    typedef enum logic {
        DB_DEASSERTED = 1'b0,
        DB_ASSERTED   = 1'b1
    } db_state_t;

    // Counter width able to hold the value stable_cycles without wrapping.
    function automatic int db_cnt_width(input int stable_cycles);
        if (stable_cycles < 1) begin
            return 1;
        end
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: raw input synchronizer, polarity, stability counter,
// debounced state and edge strobes.
//
// state          | meaning
// ---------------+-----------------------------------------------
// DB_DEASSERTED  | debounced level is 0; counting samples that read asserted
// DB_ASSERTED    | debounced level is 1; counting samples that read released
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_DEFAULT,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W    = db_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [DB_SYNC_STAGES-1:0] sync_q;
    logic                      sync_lvl;
    logic                      lvl_differs;

    db_state_t                 state_q;
    db_state_t                 state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic                      rise_q;
    logic                      rise_d;
    logic                      fall_q;
    logic                      fall_d;

    // Synchronizer shifts every cycle; reset preloads the released raw level
    // so leaving reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {DB_SYNC_STAGES{IDLE_RAW}};
        end else begin
            sync_q <= {sync_q[DB_SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_lvl    = (ACTIVE_LOW != 0) ? ~sync_q[DB_SYNC_STAGES-1]
                                           :  sync_q[DB_SYNC_STAGES-1];
    assign lvl_differs = (sync_lvl != (state_q == DB_ASSERTED));

    // Next state, counter and strobes; a sample matching the current level
    // restarts the count, so a bounce just before threshold costs a full run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample_en) begin
            if (!lvl_differs) begin
                cnt_d = '0;
            end else if (cnt_q >= (CNT_TERM - CNT_ONE)) begin
                cnt_d = '0;
                case (state_q)
                    DB_DEASSERTED: begin
                        state_d = DB_ASSERTED;
                        rise_d  = 1'b1;
                    end
                    DB_ASSERTED: begin
                        state_d = DB_DEASSERTED;
                        fall_d  = 1'b1;
                    end
                    default: begin
                        state_d = DB_DEASSERTED;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State, counter and strobe registers; reset discards any count in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DB_DEASSERTED;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_out     = (state_q == DB_ASSERTED);
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// Bank of independent debounce channels sharing one clock, reset and
// sample-qualify tick. All outputs come straight from channel flops.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = DB_STABLE_DEFAULT,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    // One channel instance per raw input bit.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .sample_en  (sample_en),
            .raw_in     (raw_in[i]),
            .db_out     (db_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench: two debouncers (active-low and active-high, 4 channels,
// 4 stable samples). The driver feeds a behavioural model that predicts
// strobe events into a queue; a monitor compares DUT strobes and levels.
module tb_debounce_multi;

    localparam int CH = 4;
    localparam int S  = 4;

    typedef struct {
        int edge_n;
        int inst;
        int ch;
        bit rise;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b1;
    logic [CH-1:0] raw_a = 4'hF;
    logic [CH-1:0] raw_b = 4'h0;
    logic [CH-1:0] db_a, rise_a, fall_a;
    logic [CH-1:0] db_b, rise_b, fall_b;

    int  n_cmp  = 0;
    int  n_fail = 0;
    int  edge_cnt = 0;
    bit  started = 0;
    int  last_step_edge = 0;

    ev_t exp_q[$];

    // model state: raw delay line, qualified-sample history, debounced level
    bit  dly0[2][CH];
    bit  dly1[2][CH];
    bit  hist[2*CH][$];
    bit  lvl[2][CH];

    // observations gathered by the monitor
    int  last_rise[2][CH];
    int  last_fall[2][CH];
    int  rise_n[2][CH];
    logic [CH-1:0] fall_snap = '0;

    debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(S), .ACTIVE_LOW(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .raw_in     (raw_a),
        .db_out     (db_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a)
    );

    debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(S), .ACTIVE_LOW(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .raw_in     (raw_b),
        .db_out     (db_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Behavioural rules for the upcoming edge k: the level seen by the
    // debouncer is the raw value captured two edges earlier; the level flips
    // once the last S qualified samples since the previous flip all differ.
    task automatic model_eval(input int k);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                bit raw;
                bit idle;
                bit used;
                bit asserted;
                bit all_diff;
                raw  = (i == 0) ? raw_a[c] : raw_b[c];
                idle = (i == 0);
                if (rst) begin
                    dly0[i][c] = idle;
                    dly1[i][c] = idle;
                    lvl[i][c]  = 1'b0;
                    hist[i*CH+c].delete();
                end else begin
                    used       = dly0[i][c];
                    dly0[i][c] = dly1[i][c];
                    dly1[i][c] = raw;
                    asserted   = (i == 0) ? ~used : used;
                    if (sample_en) begin
                        hist[i*CH+c].push_back(asserted != lvl[i][c]);
                        if (hist[i*CH+c].size() > S) void'(hist[i*CH+c].pop_front());
                        all_diff = (hist[i*CH+c].size() == S);
                        foreach (hist[i*CH+c][j]) if (!hist[i*CH+c][j]) all_diff = 0;
                        if (all_diff) begin
                            ev_t e;
                            e.edge_n = k;
                            e.inst   = i;
                            e.ch     = c;
                            e.rise   = ~lvl[i][c];
                            exp_q.push_back(e);
                            lvl[i][c] = ~lvl[i][c];
                            hist[i*CH+c].delete();
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [CH-1:0] ra, input logic [CH-1:0] rb,
                        input logic en, input logic r);
        @(negedge clk);
        raw_a     = ra;
        raw_b     = rb;
        sample_en = en;
        rst       = r;
        last_step_edge = edge_cnt + 1;
        model_eval(last_step_edge);
        started = 1;
    endtask

    task automatic hold(input int n);
        repeat (n) step(raw_a, raw_b, sample_en, rst);
    endtask

    // Monitor: compares levels every cycle and pops one expected event per
    // observed strobe.
    always @(posedge clk) begin
        #1;
        if (started) begin
            logic [CH-1:0] rs [2];
            logic [CH-1:0] fs [2];
            logic [CH-1:0] exp_lvl [2];
            int n;
            n = edge_cnt;
            rs[0] = rise_a; fs[0] = fall_a;
            rs[1] = rise_b; fs[1] = fall_b;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < CH; c++) exp_lvl[i][c] = lvl[i][c];
            while (exp_q.size() > 0 && exp_q[0].edge_n < n) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missing_pulse: inst %0d ch %0d rise %0d got none, expected at edge %0d",
                         exp_q[0].inst, exp_q[0].ch, exp_q[0].rise, exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end
            check("db_out_a", int'(db_a), int'(exp_lvl[0]));
            check("db_out_b", int'(db_b), int'(exp_lvl[1]));
            if (fall_a != 0) fall_snap = fall_a;
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < CH; c++) begin
                    if (rs[i][c] || fs[i][c]) begin
                        check("rise_and_fall", int'(rs[i][c] && fs[i][c]), 0);
                        if (rs[i][c]) begin
                            last_rise[i][c] = n;
                            rise_n[i][c]++;
                        end
                        if (fs[i][c]) last_fall[i][c] = n;
                        if (exp_q.size() == 0 || exp_q[0].edge_n != n) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_pulse: inst %0d ch %0d rise %0d at edge %0d, expected no pulse",
                                     i, c, rs[i][c], n);
                        end else begin
                            check("pulse_chan", i*CH + c, exp_q[0].inst*CH + exp_q[0].ch);
                            check("pulse_kind", int'(rs[i][c]), int'(exp_q[0].rise));
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int ef, er, ep, r1, eb, rsv;
        logic [CH-1:0] ra, rb;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < CH; c++) begin
                last_rise[i][c] = -1;
                last_fall[i][c] = -1;
                rise_n[i][c]    = 0;
            end

        // reset and idle
        repeat (3) step(4'hF, 4'h0, 1'b1, 1'b1);
        step(4'hF, 4'h0, 1'b1, 1'b0);
        hold(4);
        check("reset_db_a", int'(db_a), 0);
        check("reset_rise_a", int'(rise_a), 0);
        check("reset_fall_a", int'(fall_a), 0);

        // Latency counts the sampling edge as the first of 2+S edges.
        // clean press on channel 0
        step(4'hE, 4'h0, 1'b1, 1'b0);
        ef = last_step_edge;
        hold(8);
        check("press_latency", last_rise[0][0], ef + S + 1);
        check("press_count", rise_n[0][0], 1);

        // bounce on channel 1: low 3, high 1, low held
        repeat (3) step(4'hC, 4'h0, 1'b1, 1'b0);
        step(4'hE, 4'h0, 1'b1, 1'b0);
        step(4'hC, 4'h0, 1'b1, 1'b0);
        ef = last_step_edge;
        hold(10);
        check("bounce_latency", last_rise[0][1], ef + S + 1);
        check("bounce_count", rise_n[0][1], 1);

        // assert channel 2, then release 0 and 2 together
        step(4'h8, 4'h0, 1'b1, 1'b0);
        hold(8);
        step(4'hD, 4'h0, 1'b1, 1'b0);
        er = last_step_edge;
        hold(8);
        check("release_ch0", last_fall[0][0], er + S + 1);
        check("release_ch2", last_fall[0][2], er + S + 1);
        check("release_vec", int'(fall_snap), 5);

        // prescale: one qualified sample in four, channel 3 pressed
        for (int i = 0; i < 24; i++) begin
            step(4'h5, 4'h0, (i % 4) == 0, 1'b0);
            if (i == 0) ep = last_step_edge;
        end
        check("prescale_latency", last_rise[0][3], ep + 4 * S);
        check("prescale_count", rise_n[0][3], 1);

        // reset after three of four samples on channel 0
        rsv = rise_n[0][0];
        step(4'h4, 4'h0, 1'b1, 1'b0);
        hold(S);
        step(4'h4, 4'h0, 1'b1, 1'b1);
        check("reset_midcount_nopulse", rise_n[0][0], rsv);
        step(4'h4, 4'h0, 1'b1, 1'b0);
        r1 = last_step_edge;
        hold(8);
        check("reset_restart_latency", last_rise[0][0], r1 + S + 1);
        check("reset_restart_count", rise_n[0][0], rsv + 1);

        // active-high instance
        step(4'h4, 4'h1, 1'b1, 1'b0);
        eb = last_step_edge;
        hold(8);
        check("polarity_latency", last_rise[1][0], eb + S + 1);
        check("polarity_db", int'(db_b[0]), 1);

        // randomized stimulus against the model
        ra = raw_a;
        rb = raw_b;
        for (int t = 0; t < 3000; t++) begin
            int rate;
            rate = (t < 1500) ? 7 : 15;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, rate) == 0) ra[c] = ~ra[c];
                if ($urandom_range(0, rate) == 0) rb[c] = ~rb[c];
            end
            step(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end
        step(ra, rb, 1'b1, 1'b0);
        hold(12);
        check("events_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
